// File: rtl/pipe_stage.sv
// pipe_stage: elastic valid/ready pipeline stage register with optional two-entry skid buffer
module pipe_stage #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        count
);
    localparam logic [1:0] EMPTY = 2'd0, FULL = 2'd1, SKIDFULL = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              enq, deq, load_main, load_skid, pop_skid;

    assign enq = in_valid && in_ready;
    assign deq = out_valid && out_ready;
    // Main entry takes the input when it is free or being drained this cycle; skid takes it when main is stuck.
    assign load_main = !flush && enq && (state == EMPTY || (state == FULL && deq));
    assign load_skid = !flush && enq && state == FULL && !deq;
    assign pop_skid  = !flush && deq && state == SKIDFULL;

    // State register; occupancy doubles as the state encoding
    always_ff @(posedge clk)
        state <= rst ? EMPTY : state_nxt;

    // Next state; flush empties the stage regardless of the handshake
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else
            case (state)
                EMPTY:    state_nxt = enq ? FULL : EMPTY;
                FULL:     state_nxt = (enq && !deq && SKID != 0) ? SKIDFULL : (deq && !enq) ? EMPTY : FULL;
                SKIDFULL: state_nxt = deq ? FULL : SKIDFULL;
                default:  state_nxt = EMPTY;
            endcase
    end

    // Outputs come straight from state and main entry; ctrl is masked so bubbles carry no side effects
    always_comb begin
        out_valid = state != EMPTY;
        count     = state;
        out_data  = main_data;
        out_ctrl  = out_valid ? main_ctrl : '0;
    end

    // Payload storage; flush kills ctrl only, data is left as-is since it is harmless without ctrl
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (pop_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;
            // Registered ready cuts the out_ready -> in_ready path; the skid entry absorbs the in-flight input
            always_ff @(posedge clk)
                rdy_q <= rst ? 1'b1 : state_nxt != SKIDFULL;
            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: randomized scoreboard bench running both skid configurations side by side
module tb_pipe_stage;
    logic              clk = 0;
    logic              rst, in_valid, out_ready, flush;
    logic [15:0]       in_data;
    logic [7:0]        in_ctrl;
    logic [1:0]        rdy, ov;
    logic [1:0][15:0]  od;
    logic [1:0][7:0]   oc;
    logic [1:0][1:0]   cnt;
    int                n_chk = 0, n_err = 0;
    bit                chk_en = 0;
    logic [23:0]       mq [2][2];
    int                mn [2];
    logic [15:0]       last [2];

    always #5 clk = ~clk;

    pipe_stage #(.DATA_W(16), .CTRL_W(8), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_ctrl(oc[0]), .flush(flush), .count(cnt[0]));

    pipe_stage #(.DATA_W(16), .CTRL_W(8), .SKID(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_ctrl(oc[1]), .flush(flush), .count(cnt[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, compare both DUTs with the FIFO model, then advance the model past the edge
    task automatic step(input logic v, input logic [15:0] d, input logic [7:0] c,
                        input logic r, input logic f, input logic rs);
        @(negedge clk);
        in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f; rst = rs;
        #1;
        for (int m = 0; m < 2; m++) begin
            logic rdy_e, dq, eq;
            rdy_e = (m == 1) ? (mn[m] != 2) : (mn[m] == 0 || r);
            if (chk_en) begin
                chk($sformatf("in_ready%0d", m), 32'(rdy[m]), 32'(rdy_e));
                chk($sformatf("out_valid%0d", m), 32'(ov[m]), 32'(mn[m] > 0));
                chk($sformatf("out_data%0d", m), 32'(od[m]), 32'(mn[m] > 0 ? mq[m][0][15:0] : last[m]));
                chk($sformatf("out_ctrl%0d", m), 32'(oc[m]), 32'(mn[m] > 0 ? mq[m][0][23:16] : 8'h00));
                chk($sformatf("count%0d", m), 32'(cnt[m]), 32'(mn[m]));
            end
            if (rs) begin
                mn[m] = 0;
                last[m] = 16'h0;
            end else if (f) begin
                mn[m] = 0;
            end else begin
                dq = mn[m] > 0 && r;
                eq = v && rdy_e;
                if (dq) begin
                    mq[m][0] = mq[m][1];
                    mn[m]--;
                end
                if (eq) begin
                    mq[m][mn[m]] = {c, d};
                    mn[m]++;
                end
                if (mn[m] > 0) last[m] = mq[m][0][15:0];
            end
        end
    endtask

    initial begin
        mn[0] = 0; mn[1] = 0; last[0] = 0; last[1] = 0;
        step(1, 16'h1234, 8'hFF, 0, 0, 1);
        step(1, 16'h1234, 8'hFF, 0, 0, 1);
        chk_en = 1;
        step(0, 16'h0, 8'h0, 1, 0, 0);
        for (int i = 1; i <= 16; i++) step(1, 16'(i), 8'(i), 1, 0, 0);
        step(0, 16'h0, 8'h0, 1, 0, 0);
        step(0, 16'h0, 8'h0, 1, 0, 0);
        step(1, 16'hA, 8'h0A, 1, 0, 0);
        step(1, 16'hB, 8'h0B, 0, 0, 0);
        @(posedge clk) #1;
        chk("stall_count", 32'(cnt[1]), 32'd2);
        chk("stall_ready", 32'(rdy[1]), 32'd0);
        chk("stall_data", 32'(od[1]), 32'hA);
        step(0, 16'h0, 8'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 16'h0, 8'h0, 1, 0, 0);
        step(1, 16'hC1C1, 8'h81, 0, 0, 0);
        step(1, 16'hC2C2, 8'h42, 0, 0, 0);
        step(1, 16'hDEAD, 8'hFF, 0, 1, 0);
        @(posedge clk) #1;
        chk("flush_valid", 32'(ov[1]), 32'd0);
        chk("flush_count", 32'(cnt[1]), 32'd0);
        chk("flush_ctrl", 32'(oc[1]), 32'd0);
        chk("flush_data", 32'(od[1]), 32'hC1C1);
        step(1, 16'h5555, 8'h55, 0, 0, 0);
        for (int i = 0; i < 100; i++)
            step(1, 16'($urandom), 8'($urandom), 1'(i % 2), 0, 0);
        for (int i = 0; i < 1000; i++)
            step(1'($urandom % 4 != 0), 16'($urandom), 8'($urandom), 1'($urandom % 3 != 0),
                 1'($urandom % 25 == 0), 1'($urandom % 200 == 0));
        for (int i = 0; i < 4; i++) step(0, 16'h0, 8'h0, 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised elastic pipeline stage register for the inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed-field, always-load stage registers with a valid/ready stage. The stage holds one instruction's datapath payload and control bits. It supports stall back-pressure and synchronous flush (bubble insertion). An optional two-entry skid buffer breaks the combinational ready path between stages.

## Interface
Parameters:
- DATA_W, 16: datapath payload width (ALU result, PC+2, operands); not cleared by flush.
- CTRL_W, 8: control payload width (RegWrite, MemWrite, MemRead, halt, …); zeroed by reset and flush.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts the input this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream consumes the output this cycle.
- out_data  out  DATA_W  output datapath payload.
- out_ctrl  out  CTRL_W  output control payload; forced to 0 when out_valid = 0.
- flush  in  1  synchronous kill of all held entries (branch mispredict or exception).
- count  out  2  entries held: 0, 1, or 2 (2 only when SKID = 1).

## Operation
- Enqueue: in_valid && in_ready at the edge. Dequeue: out_valid && out_ready at the edge.
- Storage: main entry (drives outputs) and, when SKID = 1, a skid entry. Each entry holds data and ctrl.
- States: EMPTY (count 0), FULL (count 1), SKIDFULL (count 2, SKID = 1 only). out_valid = (state != EMPTY).
- SKID = 1 transitions and data moves:
  - EMPTY + enq -> FULL; main <= in.
  - FULL + enq + deq -> FULL; main <= in.
  - FULL + enq, no deq -> SKIDFULL; skid <= in.
  - FULL + deq, no enq -> EMPTY.
  - SKIDFULL + deq -> FULL; main <= skid.
  - in_ready is a flop equal to (next state != SKIDFULL). Enqueue is impossible in SKIDFULL.
- SKID = 0: in_ready = !out_valid || out_ready (combinational). Transitions are the FULL/EMPTY subset above.
- Hold: with no enq and no deq, all entries and outputs stay unchanged. This is the stall behaviour.
- Flush, taking priority over enq/deq:
  - state <= EMPTY, count <= 0.
  - ctrl of both entries <= 0.
  - data entries keep their old values.
  - An input presented in the flush cycle is discarded. A dequeue in the flush cycle still counts as consumed downstream.
- Reset, taking priority over flush: state EMPTY and all data and ctrl registers 0.
- Reset values: out_valid 0, out_data 0, out_ctrl 0, count 0. in_ready is 1 in the cycle after reset in both modes (SKID = 1 flop resets to 1).
- Ordering: strict FIFO. Never duplicate or drop an accepted entry except by flush or reset.

## Timing
- Latency: 1 cycle. An entry accepted at edge N appears on out_* after edge N when the stage was EMPTY, or behind one or two older entries.
- Throughput: 1 entry per cycle in steady state with out_ready held at 1, in both modes.
- SKID = 1:
  - No combinational path from out_ready or flush to in_ready.
  - in_ready falls 1 cycle after the stall begins. The skid entry absorbs the one in-flight input.
- SKID = 0: out_ready -> in_ready combinational path allowed (same-cycle stall propagation).
- out_data and out_ctrl change only at clock edges. No combinational input -> output path exists except out_ready -> in_ready when SKID = 0.
- Simultaneous flush + enq + deq: result EMPTY, nothing retained.
- Reset asserted mid-stream: outputs are zero on the next edge regardless of other inputs.

## Test plan
- Reset: assert rst 2 cycles with in_valid = 1, in_ctrl = 8'hFF -> out_valid 0, out_ctrl 0, out_data 0, count 0, in_ready 1 after release.
- Streaming: out_ready = 1; send data 16'h0001..16'h0010, one per cycle -> identical sequence on out_data, 1-cycle latency, no gaps, count stays ≤1.
- Stall (SKID = 1):
  - Send 16'hA, 16'hB back-to-back, drop out_ready after A arrives -> count 2, in_ready 0 the next cycle, out_data holds 16'hA.
  - Raise out_ready -> A then B in order; in_ready returns to 1 once count ≤1.
- Flush: hold 2 entries (ctrl 8'h81, 8'h42), assert flush with in_valid = 1 -> next cycle out_valid 0, out_ctrl 0, count 0, input discarded, out_data unchanged.
- SKID = 0 comb ready: FULL with out_ready toggling 1/0 each cycle -> in_ready mirrors out_ready in the same cycle; no entry lost or duplicated over 50 random entries.
- Random back-pressure: scoreboard check of 1000 random in_valid/out_ready/flush patterns in both SKID values -> in-order delivery, ctrl zero whenever out_valid = 0, count matches model.
